// File: rtl/pong_graph_animate.sv
// Pong pixel generation and per-frame animation: wall/paddle/ball drawing,
// paddle control from buttons, and the IDLE/PLAY/MISS game FSM.
// Optional build macro: PONG_AUTOSERVE_EN -- IDLE also serves by itself
// after MISS_FRAMES refresh ticks without a button press.
module pong_graph_animate #(
  parameter int unsigned PADDLE_H    = 72,
  parameter int unsigned PADDLE_V    = 4,
  parameter int unsigned BALL_V      = 2,
  parameter int unsigned MISS_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_tick,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [11:0] rgb,
  output logic        hit,
  output logic        miss
);

  localparam int unsigned PW = 10;
  localparam int unsigned XW = PW + 1;
  localparam int unsigned CW = (MISS_FRAMES > 2) ? $clog2(MISS_FRAMES) : 1;

  localparam logic [PW-1:0] WALL_L   = PW'(32);
  localparam logic [PW-1:0] WALL_R   = PW'(35);
  localparam logic [PW-1:0] WALL_HIT = PW'(36);
  localparam logic [PW-1:0] PAD_L    = PW'(600);
  localparam logic [PW-1:0] PAD_R    = PW'(603);
  localparam logic [PW-1:0] X_OUT    = PW'(640);
  localparam logic [PW-1:0] PARK_X   = PW'(580);
  localparam logic [PW-1:0] PARK_Y   = PW'(238);
  localparam logic [PW-1:0] PAD_INIT = PW'(204);
  localparam logic [PW-1:0] PAD_MAX  = PW'(480 - PADDLE_H);
  localparam logic [PW-1:0] BV       = PW'(BALL_V);
  localparam logic [PW-1:0] PV       = PW'(PADDLE_V);
  localparam logic [XW-1:0] Y_BOT    = XW'(479 - BALL_V);
  localparam logic [CW-1:0] CNT_LAST = CW'(MISS_FRAMES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_MISS} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [PW-1:0] paddle_y, paddle_nxt;
  logic [PW-1:0] ball_x, ball_x_nxt, ball_y, ball_y_nxt;
  logic          dx_neg, dx_neg_nxt, dy_neg, dy_neg_nxt;
  logic          hit_nxt, miss_nxt;
  logic [11:0]   color_c;

  logic          refr_tick;
  logic [XW-1:0] bx_end, by_end, pad_end;
  logic          overlap;

  assign refr_tick = pixel_tick && (pixel_x == PW'(0)) && (pixel_y == PW'(481));
  assign bx_end    = XW'(ball_x) + XW'(7);
  assign by_end    = XW'(ball_y) + XW'(7);
  assign pad_end   = XW'(paddle_y) + XW'(PADDLE_H - 1);
  assign overlap   = (XW'(ball_y) <= pad_end) && (by_end >= XW'(paddle_y));

  // State, positions and event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      paddle_y <= PAD_INIT;
      ball_x   <= PARK_X;
      ball_y   <= PARK_Y;
      dx_neg   <= 1'b1;
      dy_neg   <= 1'b0;
      hit      <= 1'b0;
      miss     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      paddle_y <= paddle_nxt;
      ball_x   <= ball_x_nxt;
      ball_y   <= ball_y_nxt;
      dx_neg   <= dx_neg_nxt;
      dy_neg   <= dy_neg_nxt;
      hit      <= hit_nxt;
      miss     <= miss_nxt;
    end
  end

  // Per-frame paddle move, ball physics and game FSM
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    paddle_nxt = paddle_y;
    ball_x_nxt = ball_x;
    ball_y_nxt = ball_y;
    dx_neg_nxt = dx_neg;
    dy_neg_nxt = dy_neg;
    hit_nxt    = 1'b0;
    miss_nxt   = 1'b0;
    if (refr_tick) begin
      if (btn_up && !btn_down) begin
        paddle_nxt = (paddle_y > PV) ? paddle_y - PV : '0;
      end else if (btn_down && !btn_up) begin
        paddle_nxt = ((XW'(paddle_y) + XW'(PADDLE_V)) > XW'(PAD_MAX)) ? PAD_MAX : paddle_y + PV;
      end
      case (state)
        ST_IDLE: begin
          ball_x_nxt = PARK_X;
          ball_y_nxt = PARK_Y;
          dx_neg_nxt = 1'b1;
          dy_neg_nxt = 1'b0;
          if (btn_up || btn_down) begin
            state_nxt = ST_PLAY;
          end
`ifdef PONG_AUTOSERVE_EN
          else if (cnt == CNT_LAST) begin
            state_nxt = ST_PLAY;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
`else
          else begin
            state_nxt = ST_IDLE;
          end
`endif
        end
        ST_PLAY: begin
          // wall checks precede the paddle check, so a wall bounce wins
          if (ball_y <= BV) begin
            dy_neg_nxt = 1'b0;
          end else if (by_end >= Y_BOT) begin
            dy_neg_nxt = 1'b1;
          end
          if (ball_x <= WALL_HIT) begin
            dx_neg_nxt = 1'b0;
          end else if (!dx_neg && (bx_end >= XW'(PAD_L)) && (bx_end <= XW'(PAD_R)) && overlap) begin
            dx_neg_nxt = 1'b1;
            hit_nxt    = 1'b1;
          end
          if (ball_x >= X_OUT) begin
            miss_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_MISS;
          end else begin
            ball_x_nxt = dx_neg_nxt ? ball_x - BV : ball_x + BV;
            ball_y_nxt = dy_neg_nxt ? ball_y - BV : ball_y + BV;
          end
        end
        ST_MISS: begin
          if (cnt == CNT_LAST) begin
            state_nxt  = ST_IDLE;
            cnt_nxt    = '0;
            ball_x_nxt = PARK_X;
            ball_y_nxt = PARK_Y;
            dx_neg_nxt = 1'b1;
            dy_neg_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Object selection for the current pixel, wall > paddle > ball
  always_comb begin
    color_c = 12'h000;
    if ((pixel_x >= WALL_L) && (pixel_x <= WALL_R)) begin
      color_c = 12'h00f;
    end else if ((pixel_x >= PAD_L) && (pixel_x <= PAD_R) &&
                 (pixel_y >= paddle_y) && (XW'(pixel_y) <= pad_end)) begin
      color_c = 12'h0f0;
    end else if ((state != ST_MISS) &&
                 (pixel_x >= ball_x) && (XW'(pixel_x) <= bx_end) &&
                 (pixel_y >= ball_y) && (XW'(pixel_y) <= by_end)) begin
      color_c = 12'hf00;
    end
  end

  // Registered colour output, blanked outside the visible area
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb <= 12'h000;
    end else begin
      rgb <= video_on ? color_c : 12'h000;
    end
  end

endmodule

// File: tb/tb_pong_graph_animate.sv
// Randomized bench for pong_graph_animate: drives pixel coordinates
// directly (short synthetic frames) and checks rgb/hit/miss against a
// game-level reference model.
module tb_pong_graph_animate;

  localparam int PH = 72;
  localparam int PV = 4;
  localparam int BV = 2;
  localparam int MF = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_tick;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        btn_up;
  logic        btn_down;
  logic [11:0] rgb;
  logic        hit;
  logic        miss;

  pong_graph_animate #(
    .PADDLE_H(PH), .PADDLE_V(PV), .BALL_V(BV), .MISS_FRAMES(MF)
  ) dut (
    .clk(clk), .rst(rst), .pixel_tick(pixel_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .btn_up(btn_up), .btn_down(btn_down),
    .rgb(rgb), .hit(hit), .miss(miss)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // game model: mode 0=idle 1=play 2=miss; signed per-axis velocities
  int m_mode, m_py, m_bx, m_by, m_dx, m_dy, m_cnt;
  int n_hits = 0;
  int n_miss = 0;

  function automatic void model_park();
    m_bx = 580; m_by = 238; m_dx = -BV; m_dy = BV;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_py = 204; m_cnt = 0;
    model_park();
  endfunction

  function automatic logic [11:0] exp_rgb(input int x, input int y, input bit von);
    if (!von) return 12'h000;
    if (x >= 32 && x <= 35) return 12'h00f;
    if (x >= 600 && x <= 603 && y >= m_py && y < m_py + PH) return 12'h0f0;
    if (m_mode != 2 && x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return 12'hf00;
    return 12'h000;
  endfunction

  function automatic void model_tick(input bit up, input bit dn, output bit eh, output bit em);
    int old_py;
    old_py = m_py;
    eh = 0; em = 0;
    if (up && !dn) m_py = (m_py - PV < 0) ? 0 : m_py - PV;
    else if (dn && !up) m_py = (m_py + PV > 480 - PH) ? 480 - PH : m_py + PV;
    case (m_mode)
      0: begin
        if (up || dn) m_mode = 1;
`ifdef PONG_AUTOSERVE_EN
        else begin
          m_cnt++;
          if (m_cnt == MF) m_mode = 1;
        end
`endif
      end
      1: begin
        if (m_bx >= 640) begin
          em = 1; m_mode = 2; m_cnt = 0; n_miss++;
        end else begin
          if (m_by <= BV) m_dy = BV;
          else if (m_by + 7 >= 479 - BV) m_dy = -BV;
          if (m_bx <= 36) m_dx = BV;
          else if (m_dx > 0 && m_bx + 7 >= 600 && m_bx + 7 <= 603 &&
                   m_by <= old_py + PH - 1 && m_by + 7 >= old_py) begin
            m_dx = -BV; eh = 1; n_hits++;
          end
          m_bx = (m_bx + m_dx) & 1023;
          m_by = (m_by + m_dy) & 1023;
        end
      end
      default: begin
        m_cnt++;
        if (m_cnt == MF) begin
          m_mode = 0; m_cnt = 0;
          model_park();
        end
      end
    endcase
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // one pixel probe: drive coordinates, check registered colour next clk
  task automatic probe(input int kind);
    int x, y;
    bit von, tk;
    tk = ($urandom_range(0, 3) == 0);
    case (kind)
      0: begin x = m_bx - 3 + $urandom_range(0, 13); y = m_by - 3 + $urandom_range(0, 13); end
      1: begin x = 597 + $urandom_range(0, 9); y = m_py - 3 + $urandom_range(0, PH + 5); end
      2: begin x = 29 + $urandom_range(0, 9); y = $urandom_range(0, 524); end
      3: begin x = $urandom_range(0, 799); y = $urandom_range(0, 524); end
      default: begin
        case ($urandom_range(0, 3))
          0: begin x = 0; y = 481; tk = 0; end
          1: begin x = 1; y = 481; tk = 1; end
          2: begin x = 0; y = 480; tk = 1; end
          default: begin x = 0; y = 482; tk = 1; end
        endcase
      end
    endcase
    x = clampi(x, 0, 799);
    y = clampi(y, 0, 524);
    if (x == 0 && y == 481) tk = 0;
    von = (x < 640 && y < 480) ? ($urandom_range(0, 7) != 0) : 1'b0;
    @(negedge clk);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = von; pixel_tick = tk;
    @(negedge clk);
    pixel_tick = 1'b0;
    check("rgb", 32'(rgb), 32'(exp_rgb(x, y, von)));
    check("hit_idle", 32'(hit), 32'd0);
    check("miss_idle", 32'(miss), 32'd0);
  endtask

  // one synthetic frame: probes then a single refresh tick
  task automatic frame(input bit up, input bit dn);
    bit eh, em;
    for (int k = 0; k < 5; k++) probe(k);
    @(negedge clk);
    pixel_x = 10'd0; pixel_y = 10'd481; video_on = 1'b0; pixel_tick = 1'b1;
    btn_up = up; btn_down = dn;
    model_tick(up, dn, eh, em);
    @(negedge clk);
    pixel_tick = 1'b0;
    check("hit", 32'(hit), 32'(eh));
    check("miss", 32'(miss), 32'(em));
  endtask

  task automatic rand_btn(output bit up, output bit dn);
    int r;
    r = $urandom_range(0, 3);
    up = r[0]; dn = r[1];
  endtask

  initial begin
    bit up, dn;
    int seg;
    rst = 1'b1; pixel_tick = 1'b0; video_on = 1'b0;
    pixel_x = '0; pixel_y = '0; btn_up = 1'b0; btn_down = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_miss", 32'(miss), 32'd0);
    rst = 1'b0;

    // idle with no buttons: parked ball, or autoserve when built in
    for (int f = 0; f < 200; f++) frame(1'b0, 1'b0);

    // random buttons, then biased runs into both paddle clamps
    for (int f = 0; f < 120; f++) begin rand_btn(up, dn); frame(up, dn); end
    for (int f = 0; f < 100; f++) begin
      dn = ($urandom_range(0, 4) != 0); frame(1'b0, dn);
    end
    for (int f = 0; f < 140; f++) begin
      up = ($urandom_range(0, 4) != 0); frame(up, 1'b0);
    end

    // game: alternate chasing and avoiding the ball
    for (int s = 0; s < 3; s++) begin
      seg = (s == 2) ? 500 : 700;
      for (int f = 0; f < seg; f++) begin
        if (m_mode != 1 || $urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 3) == 0) rand_btn(up, dn);
          else begin up = 0; dn = 0; end
        end else begin
          int d;
          d = (m_by + 4) - (m_py + PH / 2);
          if (s == 1) d = -d;
          up = (d < -2); dn = (d > 2);
        end
        frame(up, dn);
      end
    end

    // asynchronous reset in the middle of a visible line during play
    for (int f = 0; f < 600 && !(m_mode == 1 && m_bx < 620 && m_by < 470); f++) begin
      up = (m_mode == 0); frame(up, 1'b0);
    end
    begin
      int x, y;
      bit von;
      x = m_bx + 3; y = m_by + 3;
      von = (x < 640 && y < 480);
      @(negedge clk);
      pixel_x = 10'(x); pixel_y = 10'(y); video_on = von; pixel_tick = 1'b0;
      @(negedge clk);
      check("rgb_pre_rst", 32'(rgb), 32'(exp_rgb(x, y, von)));
      rst = 1'b1;
      #1;
      check("rgb_async_rst", 32'(rgb), 32'd0);
      check("hit_async_rst", 32'(hit), 32'd0);
      check("miss_async_rst", 32'(miss), 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
    end
    for (int f = 0; f < 30; f++) frame(1'b0, 1'b0);

    $display("info: model saw %0d hits and %0d misses", n_hits, n_miss);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
